// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps {x,y,z} through all 8 input vectors, samples two
// function units (fa, fb) after a settle delay and reports tables, mismatch count and equivalence.
module tt_sweep_ctrl #(
   parameter int SETTLE_CYC = 1,
   parameter int GRAY_ORDER = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       x,
   output logic       y,
   output logic       z,
   input  logic       fa,
   input  logic       fb,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt_a,
   output logic [7:0] tt_b,
   output logic [3:0] mismatch_cnt,
   output logic [2:0] first_bad,
   output logic       first_bad_vld,
   output logic       equiv
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] LP_SETTLE     = SETTLE_CYC[3:0];
   localparam logic       LP_HAS_SETTLE = (SETTLE_CYC != 0);

   state_t     r_state;
   logic [2:0] r_step;
   logic [3:0] r_wait;
   logic [2:0] r_vec;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_ttA;
   logic [7:0] r_ttB;
   logic [3:0] r_cnt;
   logic [2:0] r_firstBad;
   logic       r_vld;
   logic       r_equiv;

   logic       w_mis;
   logic [3:0] w_cntNext;
   logic [2:0] w_stepNext;

   // Application order of the vectors: plain binary or reflected Gray code.
   function automatic logic [2:0] vecOf(input logic [2:0] s);
      if (GRAY_ORDER != 0) begin
         return s ^ (s >> 1);
      end
      return s;
   endfunction

   assign w_mis      = fa ^ fb;
   assign w_cntNext  = r_cnt + {3'b000, w_mis};
   assign w_stepNext = r_step + 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_step     <= 3'd0;
         r_wait     <= 4'd0;
         r_vec      <= 3'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ttA      <= 8'h00;
         r_ttB      <= 8'h00;
         r_cnt      <= 4'd0;
         r_firstBad <= 3'd0;
         r_vld      <= 1'b0;
         r_equiv    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_ttA      <= 8'h00;
                  r_ttB      <= 8'h00;
                  r_cnt      <= 4'd0;
                  r_firstBad <= 3'd0;
                  r_vld      <= 1'b0;
                  r_equiv    <= 1'b0;
                  r_step     <= 3'd0;
                  r_vec      <= vecOf(3'd0);
                  r_busy     <= 1'b1;
                  if (LP_HAS_SETTLE) begin
                     r_wait  <= LP_SETTLE;
                     r_state <= SETTLE;
                  end else begin
                     r_state <= SAMPLE;
                  end
               end
            end
            SETTLE: begin
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_equiv <= 1'b0;
               end else begin
                  r_wait <= r_wait - 4'd1;
                  if (r_wait == 4'd1) begin
                     r_state <= SAMPLE;
                  end
               end
            end
            SAMPLE: begin
               // An abort discards this cycle's sample but keeps everything gathered so far.
               if (abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_equiv <= 1'b0;
               end else begin
                  r_ttA[r_vec] <= fa;
                  r_ttB[r_vec] <= fb;
                  if (w_mis) begin
                     r_cnt <= w_cntNext;
                     if (!r_vld) begin
                        r_firstBad <= r_vec;
                        r_vld      <= 1'b1;
                     end
                  end
                  if (r_step != 3'd7) begin
                     r_step <= w_stepNext;
                     r_vec  <= vecOf(w_stepNext);
                     if (LP_HAS_SETTLE) begin
                        r_wait  <= LP_SETTLE;
                        r_state <= SETTLE;
                     end
                  end else begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_equiv <= (w_cntNext == 4'd0);
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign x             = r_vec[2];
   assign y             = r_vec[1];
   assign z             = r_vec[0];
   assign busy          = r_busy;
   assign done          = r_done;
   assign tt_a          = r_ttA;
   assign tt_b          = r_ttB;
   assign mismatch_cnt  = r_cnt;
   assign first_bad     = r_firstBad;
   assign first_bad_vld = r_vld;
   assign equiv         = r_equiv;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: three instances (settle 1 binary, settle 1 Gray, settle 0 binary)
// each driven by a reference function f=(X|~Y|Z)&(~X|Y|Z) and a selectable second unit.
module tb_tt_sweep_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] start = 3'b000;
   logic [2:0] abort = 3'b000;
   logic [2:0][1:0] fbMode = '0;

   wire [2:0] x, y, z, fa, fb, busy, done, vld, equiv;
   wire [2:0][7:0] ttA, ttB;
   wire [2:0][3:0] cnt;
   wire [2:0][2:0] firstBad;
   wire [2:0][29:0] allOut;

   int vecCount = 0;
   int missCount = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gDut
      assign fa[g] = (x[g] | ~y[g] | z[g]) & (~x[g] | y[g] | z[g]);
      assign fb[g] = (fbMode[g] == 2'd0) ? fa[g] :
                     (fbMode[g] == 2'd1) ? 1'b0 : (fa[g] ^ (x[g] & y[g] & z[g]));
      assign allOut[g] = {x[g], y[g], z[g], busy[g], done[g], ttA[g], ttB[g], cnt[g],
                          firstBad[g], vld[g], equiv[g]};
      tt_sweep_ctrl #(
         .SETTLE_CYC((g == 2) ? 0 : 1),
         .GRAY_ORDER((g == 1) ? 1 : 0)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start        (start[g]),
         .abort        (abort[g]),
         .x            (x[g]),
         .y            (y[g]),
         .z            (z[g]),
         .fa           (fa[g]),
         .fb           (fb[g]),
         .busy         (busy[g]),
         .done         (done[g]),
         .tt_a         (ttA[g]),
         .tt_b         (ttB[g]),
         .mismatch_cnt (cnt[g]),
         .first_bad    (firstBad[g]),
         .first_bad_vld(vld[g]),
         .equiv        (equiv[g])
      );
   end

   // Leaves the bench 1ns after the edge that accepted start.
   task automatic pulseStart(input int sel);
      @(negedge clk);
      start[sel] = 1'b1;
      @(posedge clk);
      #1;
      start[sel] = 1'b0;
   endtask

   // Returns the cycle (relative to the current edge) of the first done and the pulse count.
   task automatic waitDone(input int sel, input int budget, output int firstCyc, output int pulses);
      firstCyc = -1;
      pulses = 0;
      for (int n = 1; n <= budget; n++) begin
         @(posedge clk);
         #1;
         if (done[sel] === 1'b1) begin
            pulses++;
            if (firstCyc < 0) firstCyc = n;
         end
      end
   endtask

   task automatic test_reset();
      #3;
      for (int g = 0; g < 3; g++) begin
         vecCount++;
         if (allOut[g] !== 30'd0) begin
            missCount++; $display("[TB] FAIL reset_outputs dut%0d got %h exp 0", g, allOut[g]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_equiv();
      int c, p;
      fbMode[0] = 2'd0;
      pulseStart(0);
      vecCount++;
      if (busy[0] !== 1'b1) begin missCount++; $display("[TB] FAIL equiv_busy got %b exp 1", busy[0]); end
      waitDone(0, 24, c, p);
      vecCount++;
      if (c !== 16) begin missCount++; $display("[TB] FAIL equiv_done_cycle got %0d exp 16", c); end
      vecCount++;
      if (p !== 1) begin missCount++; $display("[TB] FAIL equiv_done_pulses got %0d exp 1", p); end
      vecCount++;
      if (ttA[0] !== 8'hEB) begin missCount++; $display("[TB] FAIL equiv_tt_a got %h exp eb", ttA[0]); end
      vecCount++;
      if (ttB[0] !== 8'hEB) begin missCount++; $display("[TB] FAIL equiv_tt_b got %h exp eb", ttB[0]); end
      vecCount++;
      if (cnt[0] !== 4'd0) begin missCount++; $display("[TB] FAIL equiv_cnt got %0d exp 0", cnt[0]); end
      vecCount++;
      if ({vld[0], equiv[0], busy[0]} !== 3'b010) begin
         missCount++; $display("[TB] FAIL equiv_flags got %b exp 010", {vld[0], equiv[0], busy[0]});
      end
      vecCount++;
      if ({x[0], y[0], z[0]} !== 3'd7) begin
         missCount++; $display("[TB] FAIL equiv_xyz_hold got %0d exp 7", {x[0], y[0], z[0]});
      end
   endtask

   task automatic test_fb_zero();
      int c, p;
      fbMode[0] = 2'd1;
      pulseStart(0);
      waitDone(0, 24, c, p);
      vecCount++;
      if (c !== 16 || p !== 1) begin missCount++; $display("[TB] FAIL fbzero_done got cyc %0d pulses %0d exp 16 1", c, p); end
      vecCount++;
      if (ttA[0] !== 8'hEB) begin missCount++; $display("[TB] FAIL fbzero_tt_a got %h exp eb", ttA[0]); end
      vecCount++;
      if (ttB[0] !== 8'h00) begin missCount++; $display("[TB] FAIL fbzero_tt_b got %h exp 00", ttB[0]); end
      vecCount++;
      if (cnt[0] !== 4'd6) begin missCount++; $display("[TB] FAIL fbzero_cnt got %0d exp 6", cnt[0]); end
      vecCount++;
      if ({firstBad[0], vld[0], equiv[0]} !== 5'b000_1_0) begin
         missCount++; $display("[TB] FAIL fbzero_first got %b exp 00010", {firstBad[0], vld[0], equiv[0]});
      end
   endtask

   task automatic test_gray();
      int c, p;
      fbMode[1] = 2'd2;
      pulseStart(1);
      waitDone(1, 24, c, p);
      vecCount++;
      if (c !== 16 || p !== 1) begin missCount++; $display("[TB] FAIL gray_done got cyc %0d pulses %0d exp 16 1", c, p); end
      vecCount++;
      if (ttA[1] !== 8'hEB) begin missCount++; $display("[TB] FAIL gray_tt_a got %h exp eb", ttA[1]); end
      vecCount++;
      if (ttB[1] !== 8'h6B) begin missCount++; $display("[TB] FAIL gray_tt_b got %h exp 6b", ttB[1]); end
      vecCount++;
      if (cnt[1] !== 4'd1) begin missCount++; $display("[TB] FAIL gray_cnt got %0d exp 1", cnt[1]); end
      vecCount++;
      if ({firstBad[1], vld[1], equiv[1]} !== 5'b111_1_0) begin
         missCount++; $display("[TB] FAIL gray_first got %b exp 11110", {firstBad[1], vld[1], equiv[1]});
      end
      vecCount++;
      if ({x[1], y[1], z[1]} !== 3'd4) begin
         missCount++; $display("[TB] FAIL gray_last_vec got %0d exp 4", {x[1], y[1], z[1]});
      end
   endtask

   // Start stays high through the whole zero-settle sweep and is dropped once done appears.
   task automatic test_back_to_back();
      int c, p;
      fbMode[2] = 2'd0;
      c = -1;
      p = 0;
      @(negedge clk);
      start[2] = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 1; n <= 24; n++) begin
         @(posedge clk);
         #1;
         if (done[2] === 1'b1) begin
            p++;
            if (c < 0) begin c = n; start[2] = 1'b0; end
         end
      end
      start[2] = 1'b0;
      vecCount++;
      if (c !== 8) begin missCount++; $display("[TB] FAIL settle0_done_cycle got %0d exp 8", c); end
      vecCount++;
      if (p !== 1) begin missCount++; $display("[TB] FAIL settle0_done_pulses got %0d exp 1", p); end
      vecCount++;
      if ({busy[2], equiv[2], ttA[2]} !== {2'b01, 8'hEB}) begin
         missCount++; $display("[TB] FAIL settle0_result got %h exp 1eb", {busy[2], equiv[2], ttA[2]});
      end
   endtask

   task automatic test_abort();
      int c, p;
      fbMode[0] = 2'd1;
      pulseStart(0);
      repeat (6) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      vecCount++;
      if ({busy[0], done[0], equiv[0]} !== 3'b000) begin
         missCount++; $display("[TB] FAIL abort_flags got %b exp 000", {busy[0], done[0], equiv[0]});
      end
      vecCount++;
      if ({ttA[0], ttB[0]} !== 16'h0300) begin
         missCount++; $display("[TB] FAIL abort_partial_tt got %h exp 0300", {ttA[0], ttB[0]});
      end
      vecCount++;
      if ({cnt[0], vld[0], firstBad[0], x[0], y[0], z[0]} !== {4'd2, 1'b1, 3'd0, 3'd3}) begin
         missCount++; $display("[TB] FAIL abort_partial_cnt got %h exp %h",
                               {cnt[0], vld[0], firstBad[0], x[0], y[0], z[0]}, {4'd2, 1'b1, 3'd0, 3'd3});
      end
      waitDone(0, 20, c, p);
      vecCount++;
      if (p !== 0 || busy[0] !== 1'b0) begin missCount++; $display("[TB] FAIL abort_no_done got pulses %0d busy %b exp 0 0", p, busy[0]); end
      @(negedge clk);
      start[0] = 1'b1;
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      abort[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vecCount++;
      if ({busy[0], cnt[0]} !== {1'b0, 4'd2}) begin
         missCount++; $display("[TB] FAIL abort_priority got %h exp 02", {busy[0], cnt[0]});
      end
      fbMode[0] = 2'd0;
      pulseStart(0);
      waitDone(0, 24, c, p);
      vecCount++;
      if (c !== 16 || p !== 1) begin missCount++; $display("[TB] FAIL abort_rerun_done got cyc %0d pulses %0d exp 16 1", c, p); end
      vecCount++;
      if ({ttA[0], ttB[0], cnt[0], vld[0], equiv[0]} !== {8'hEB, 8'hEB, 4'd0, 1'b0, 1'b1}) begin
         missCount++; $display("[TB] FAIL abort_rerun_result got %h exp %h",
                               {ttA[0], ttB[0], cnt[0], vld[0], equiv[0]}, {8'hEB, 8'hEB, 4'd0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_reset_mid();
      int c, p;
      fbMode[0] = 2'd1;
      pulseStart(0);
      repeat (2) @(posedge clk);
      #3;
      vecCount++;
      if ({busy[0], cnt[0], ttA[0]} !== {1'b1, 4'd1, 8'h01}) begin
         missCount++; $display("[TB] FAIL rstmid_before got %h exp 1101", {busy[0], cnt[0], ttA[0]});
      end
      rst_n = 1'b0;
      #1;
      vecCount++;
      if (allOut[0] !== 30'd0) begin missCount++; $display("[TB] FAIL rstmid_async got %h exp 0", allOut[0]); end
      @(negedge clk);
      rst_n = 1'b1;
      waitDone(0, 6, c, p);
      vecCount++;
      if (p !== 0 || busy[0] !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_no_done got pulses %0d busy %b exp 0 0", p, busy[0]); end
      pulseStart(0);
      waitDone(0, 24, c, p);
      vecCount++;
      if (c !== 16 || p !== 1) begin missCount++; $display("[TB] FAIL rstmid_rerun_done got cyc %0d pulses %0d exp 16 1", c, p); end
      vecCount++;
      if ({ttA[0], ttB[0], cnt[0], firstBad[0], vld[0], equiv[0]} !== {8'hEB, 8'h00, 4'd6, 3'd0, 1'b1, 1'b0}) begin
         missCount++; $display("[TB] FAIL rstmid_rerun_result got %h exp %h",
                               {ttA[0], ttB[0], cnt[0], firstBad[0], vld[0], equiv[0]},
                               {8'hEB, 8'h00, 4'd6, 3'd0, 1'b1, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_equiv();
      test_fb_zero();
      test_gray();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, giving wait cycles after each new input vector before sampling (legal 0..15).
REQ-002 SHALL have parameter GRAY_ORDER, default 0: 0 applies vectors in binary order 0..7, 1 applies them in Gray order (0,1,3,2,6,7,5,4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, request a full 8-vector sweep.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of a running sweep.
REQ-007 SHALL have ports x, y, z, outputs, 1 each, a registered input vector driven to both function units under test; {x,y,z} forms index 0..7.
REQ-008 SHALL have ports fa and fb, inputs, 1 each, outputs of the full-expression unit and the simplified-expression unit.
REQ-009 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-011 SHALL have ports tt_a and tt_b, outputs, 8 each; bit i holds fa and fb sampled at {x,y,z}=i.
REQ-012 SHALL have port mismatch_cnt, output, 4, the number of vectors where fa!=fb (0..8).
REQ-013 SHALL have port first_bad, output, 3, the first mismatching vector in application order, qualified by first_bad_vld, output, 1.
REQ-014 SHALL have port equiv, output, 1, high after a completed sweep with zero mismatches.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE, start=1 and abort=0 SHALL clear tt_a, tt_b, mismatch_cnt, first_bad, first_bad_vld and equiv, set the step counter to 0, and drive vector(0) on x,y,z.
REQ-017 On that start, the FSM SHALL go to SETTLE with the wait counter loaded to SETTLE_CYC, or go directly to SAMPLE if SETTLE_CYC=0.
REQ-018 In SETTLE, the FSM SHALL decrement the wait counter each cycle and move to SAMPLE on the cycle it would reach 0.
REQ-019 In SAMPLE, the block SHALL write fa into tt_a[{x,y,z}] and fb into tt_b[{x,y,z}].
REQ-020 In SAMPLE, if fa!=fb the block SHALL increment mismatch_cnt; if first_bad_vld=0 it SHALL also load first_bad={x,y,z} and set first_bad_vld.
REQ-021 In SAMPLE with step<7, the block SHALL increment the step, drive the next vector, and reload SETTLE; with step=7 it SHALL go to DONE.
REQ-022 Timing: each vector SHALL take SETTLE_CYC+1 cycles; with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+8*(SETTLE_CYC+1).
REQ-023 On entering DONE, equiv SHALL be set to (final mismatch_cnt==0).
REQ-024 DONE SHALL last one cycle and then return to IDLE.
REQ-025 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-026 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-027 abort=1 in SETTLE or SAMPLE SHALL return to IDLE next edge with no done pulse and equiv=0; partial results are kept and the sample in that cycle is discarded.
REQ-028 abort has priority over start; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-029 After done, all results and x,y,z SHALL hold until the next accepted start.
REQ-030 mismatch_cnt SHALL not exceed 8, and its 4 bits are sufficient without wrap.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force IDLE and drive x, y, z, busy, done, tt_a, tt_b, mismatch_cnt, first_bad, first_bad_vld and equiv to 0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep with no done pulse; the first start after release SHALL run a complete fresh sweep.

Verification
REQ-033 Bench SHALL cover: fa=fb=(X|~Y|Z)&(~X|Y|Z), SETTLE_CYC=1 -> tt_a=tt_b=8'hEB, mismatch_cnt=0, equiv=1, done 16 cycles after the start edge.
REQ-034 Bench SHALL cover: fa as in REQ-033, fb tied 0 -> tt_b=8'h00, mismatch_cnt=6, first_bad=0, first_bad_vld=1, equiv=0.
REQ-035 Bench SHALL cover: fb=fa^(x&y&z), GRAY_ORDER=1 -> mismatch_cnt=1, first_bad=7, tt_b=8'h6B.
REQ-036 Bench SHALL cover: SETTLE_CYC=0 -> done exactly 8 cycles after the start edge; start held high during a sweep -> no restart and a single done.
REQ-037 Bench SHALL cover: abort at step 3 -> IDLE next cycle, busy=0, no done, equiv=0; a following start -> full sweep with results cleared.
REQ-038 Bench SHALL cover: rst_n pulsed low mid-SETTLE asynchronously -> all outputs 0 before the next clk edge, then a clean sweep after release.
